// File: rtl/sc_down_speed_timer.sv
// Speed-paced countdown timer: emits a one-clock tick every P prescaled units, P derived from speed.
// Optional 8-bit tick counter output enabled by defining SC_DOWNSPEEDTIMER_TICKCOUNT_EN.
module sc_down_speed_timer #(
  parameter int DOWNSPEEDTIMER_DATAWIDTH   = 8,
  parameter int DOWNSPEEDTIMER_COUNTWIDTH  = 16,
  parameter int DOWNSPEEDTIMER_BASE_PERIOD = 1000,
  parameter int DOWNSPEEDTIMER_STEP        = 8,
  parameter int DOWNSPEEDTIMER_MIN_PERIOD  = 50,
  parameter int DOWNSPEEDTIMER_PRESCALE    = 50000,
  parameter int DOWNSPEEDTIMER_PRESWIDTH   = 16
) (
  input  logic                                 SC_downSPEEDTIMER_CLOCK_50,
  input  logic                                 SC_downSPEEDTIMER_RESET_InLow,
  input  logic [DOWNSPEEDTIMER_DATAWIDTH-1:0]  SC_downSPEEDTIMER_speed_InBUS,
  input  logic                                 SC_downSPEEDTIMER_start_InLow,
  input  logic                                 SC_downSPEEDTIMER_pause_InLow,
  output logic                                 SC_downSPEEDTIMER_tick_Out,
  output logic [DOWNSPEEDTIMER_COUNTWIDTH-1:0] SC_downSPEEDTIMER_count_OutBUS,
  output logic                                 SC_downSPEEDTIMER_running_Out
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
  ,
  output logic [7:0]                           SC_downSPEEDTIMER_tickcount_OutBUS
`endif
);

  localparam int DW = DOWNSPEEDTIMER_DATAWIDTH;
  localparam int CW = DOWNSPEEDTIMER_COUNTWIDTH;
  localparam int PW = DOWNSPEEDTIMER_PRESWIDTH;
  localparam int FW = DW + CW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;

  // Evaluated at full width so a large speed clamps to the floor instead of wrapping.
  function automatic logic [CW-1:0] period_f(input logic [DW-1:0] spd);
    logic [FW-1:0] prod;
    logic [FW-1:0] span;
    prod = FW'(spd) * FW'(DOWNSPEEDTIMER_STEP);
    span = FW'(DOWNSPEEDTIMER_BASE_PERIOD - DOWNSPEEDTIMER_MIN_PERIOD);
    if (prod >= span) period_f = CW'(DOWNSPEEDTIMER_MIN_PERIOD);
    else              period_f = CW'(FW'(DOWNSPEEDTIMER_BASE_PERIOD) - prod);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pres_q,  pres_d;
  logic          tick_q,  tick_d;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
  logic [7:0]    tc_q,    tc_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pres_d  = pres_q;
    tick_d  = 1'b0;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
    tc_d    = tc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!SC_downSPEEDTIMER_start_InLow) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        count_d = period_f(SC_downSPEEDTIMER_speed_InBUS);
        pres_d  = '0;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
        tc_d    = 8'd0;
`endif
      end
      RUN, PAUSED: begin
        if (!SC_downSPEEDTIMER_start_InLow) begin
          state_d = LOAD;
        end else if (!SC_downSPEEDTIMER_pause_InLow) begin
          state_d = PAUSED;
        end else begin
          // Leaving PAUSED counts on the same edge, so a pause costs exactly its own length.
          state_d = RUN;
          if (pres_q == PW'(DOWNSPEEDTIMER_PRESCALE - 1)) begin
            pres_d = '0;
            if (count_q > CW'(1)) begin
              count_d = count_q - CW'(1);
            end else begin
              count_d = period_f(SC_downSPEEDTIMER_speed_InBUS);
              tick_d  = 1'b1;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
              tc_d    = tc_q + 8'd1;
`endif
            end
          end else begin
            pres_d = pres_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SC_downSPEEDTIMER_CLOCK_50 or negedge SC_downSPEEDTIMER_RESET_InLow) begin
    if (!SC_downSPEEDTIMER_RESET_InLow) begin
      state_q <= IDLE;
      count_q <= '0;
      pres_q  <= '0;
      tick_q  <= 1'b0;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
      tc_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pres_q  <= pres_d;
      tick_q  <= tick_d;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
      tc_q    <= tc_d;
`endif
    end
  end

  assign SC_downSPEEDTIMER_tick_Out     = tick_q;
  assign SC_downSPEEDTIMER_count_OutBUS = count_q;
  assign SC_downSPEEDTIMER_running_Out  = (state_q == RUN) || (state_q == PAUSED);
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
  assign SC_downSPEEDTIMER_tickcount_OutBUS = tc_q;
`endif

endmodule

// File: tb/tb_sc_down_speed_timer.sv
// Directed bench for sc_down_speed_timer with BASE=10, STEP=2, MIN=3, PRESCALE=2.
module tb_sc_down_speed_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  speed;
  logic        start_n;
  logic        pause_n;
  logic        tick;
  logic [15:0] count;
  logic        running;
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
  logic [7:0]  tcount;
`endif

  int total = 0;
  int bad   = 0;

  sc_down_speed_timer #(
    .DOWNSPEEDTIMER_DATAWIDTH  (8),
    .DOWNSPEEDTIMER_COUNTWIDTH (16),
    .DOWNSPEEDTIMER_BASE_PERIOD(10),
    .DOWNSPEEDTIMER_STEP       (2),
    .DOWNSPEEDTIMER_MIN_PERIOD (3),
    .DOWNSPEEDTIMER_PRESCALE   (2),
    .DOWNSPEEDTIMER_PRESWIDTH  (4)
  ) dut (
    .SC_downSPEEDTIMER_CLOCK_50    (clk),
    .SC_downSPEEDTIMER_RESET_InLow (rst_n),
    .SC_downSPEEDTIMER_speed_InBUS (speed),
    .SC_downSPEEDTIMER_start_InLow (start_n),
    .SC_downSPEEDTIMER_pause_InLow (pause_n),
    .SC_downSPEEDTIMER_tick_Out    (tick),
    .SC_downSPEEDTIMER_count_OutBUS(count),
    .SC_downSPEEDTIMER_running_Out (running)
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
    ,
    .SC_downSPEEDTIMER_tickcount_OutBUS(tcount)
`endif
  );

  always #5 clk = ~clk;

  // Pulse start for one clock; returns at the falling edge right after the LOAD->RUN edge.
  task automatic do_start();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
    @(negedge clk);
  endtask

  // Clocks until tick is seen high; returns the budget+1 if it never comes.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (n <= budget) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) return;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; speed = 8'd0; start_n = 1'b1; pause_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_running got=%b want=0", running); end
  endtask

  task automatic test_period(input logic [7:0] spd, input int p);
    int n;
    speed = spd;
    do_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_running spd=%0d got=%b want=1", spd, running); end
    total++; if (count !== 16'(p)) begin bad++; $display("FAIL load_count spd=%0d got=%0d want=%0d", spd, count, p); end
    for (int k = 0; k < 3; k++) begin
      wait_tick(200, n);
      total++; if (n !== 2 * p) begin bad++; $display("FAIL tick_interval spd=%0d k=%0d got=%0d want=%0d", spd, k, n, 2 * p); end
      total++; if (count !== 16'(p)) begin bad++; $display("FAIL reload_count spd=%0d got=%0d want=%0d", spd, count, p); end
    end
    @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_width spd=%0d got=%b want=0", spd, tick); end
  endtask

  task automatic test_pause();
    int n;
    speed = 8'd0;
    do_start();
    repeat (5) @(negedge clk);
    pause_n = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (count !== 16'd8) begin bad++; $display("FAIL pause_count got=%0d want=8", count); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL pause_running got=%b want=1", running); end
    pause_n = 1'b1;
    wait_tick(200, n);
    total++; if (n !== 15) begin bad++; $display("FAIL pause_resume got=%0d want=15", n); end
    wait_tick(200, n);
    total++; if (n !== 20) begin bad++; $display("FAIL pause_after got=%0d want=20", n); end
  endtask

  task automatic test_speed_change();
    int n;
    speed = 8'd0;
    do_start();
    repeat (4) @(negedge clk);
    speed = 8'd2;
    wait_tick(200, n);
    total++; if (n !== 16) begin bad++; $display("FAIL chg_first got=%0d want=16", n); end
    total++; if (count !== 16'd6) begin bad++; $display("FAIL chg_reload got=%0d want=6", count); end
    wait_tick(200, n);
    total++; if (n !== 12) begin bad++; $display("FAIL chg_second got=%0d want=12", n); end
  endtask

  task automatic test_restart();
    int n;
    speed = 8'd0;
    do_start();
    repeat (19) @(negedge clk);
    start_n = 1'b0;
    @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL restart_notick got=%b want=0", tick); end
    start_n = 1'b1;
    @(negedge clk);
    total++; if (count !== 16'd10) begin bad++; $display("FAIL restart_count got=%0d want=10", count); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL restart_notick2 got=%b want=0", tick); end
    wait_tick(200, n);
    total++; if (n !== 20) begin bad++; $display("FAIL restart_interval got=%0d want=20", n); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    speed = 8'd0;
    do_start();
    wait_tick(200, n);
    #2 rst_n = 1'b0;
    #1;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL arst_tick got=%b want=0", tick); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", count); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL arst_running got=%b want=0", running); end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (running !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL arst_idle got=%b/%0d want=0/0", running, count);
    end
    do_start();
    total++; if (count !== 16'd10) begin bad++; $display("FAIL arst_restart got=%0d want=10", count); end
  endtask

`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
  task automatic test_tickcount();
    int n;
    speed = 8'd5;
    do_start();
    for (int k = 0; k < 3; k++) wait_tick(200, n);
    total++; if (tcount !== 8'd3) begin bad++; $display("FAIL tc_three got=%0d want=3", tcount); end
    do_start();
    total++; if (tcount !== 8'd0) begin bad++; $display("FAIL tc_load got=%0d want=0", tcount); end
    for (int k = 0; k < 255; k++) wait_tick(200, n);
    total++; if (tcount !== 8'd255) begin bad++; $display("FAIL tc_255 got=%0d want=255", tcount); end
    wait_tick(200, n);
    total++; if (tcount !== 8'd0) begin bad++; $display("FAIL tc_wrap got=%0d want=0", tcount); end
  endtask
`endif

  initial begin
    test_reset();
    test_period(8'd0, 10);
    test_period(8'd2, 6);
    test_period(8'd5, 3);
    test_period(8'd255, 3);
    test_pause();
    test_speed_change();
    test_restart();
    test_reset_mid_run();
`ifdef SC_DOWNSPEEDTIMER_TICKCOUNT_EN
    test_tickcount();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
